// File: rtl/mxrv_csr_ctrl_pkg.sv
// Shared definitions for the CSR access controller: Zicsr funct3 encodings,
// FSM state enum, well-known CSR addresses and read/write enable levels.
package mxrv_csr_pkg;

    localparam logic [2:0] F3_CSRRW  = 3'b001;
    localparam logic [2:0] F3_CSRRS  = 3'b010;
    localparam logic [2:0] F3_CSRRC  = 3'b011;
    localparam logic [2:0] F3_CSRRWI = 3'b101;
    localparam logic [2:0] F3_CSRRSI = 3'b110;
    localparam logic [2:0] F3_CSRRCI = 3'b111;

    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MISA    = 12'h301;

    localparam logic CSR_WRITE = 1'b1;
    localparam logic CSR_READ  = 1'b0;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_READ    = 3'd1,
        ST_CAPTURE = 3'd2,
        ST_WRITE   = 3'd3,
        ST_DONE    = 3'd4
    } csr_state_e;

endpackage

// File: rtl/mxrv_csr_ctrl_if.sv
// Request, register-file and writeback signals of the CSR controller.
// Handshake: a request is accepted on a rising edge where req_valid_i and
// req_ready_o are both high; the requester holds its fields stable until then.
interface mxrv_csr_ctrl_if #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 32
);
    logic              req_valid_i;
    logic              req_ready_o;
    logic [2:0]        funct3_i;
    logic [ADDR_W-1:0] csr_addr_i;
    logic [4:0]        rs1_idx_i;
    logic [DATA_W-1:0] rs1_data_i;
    logic [4:0]        rd_idx_i;
    logic [ADDR_W-1:0] csr_addr_o;
    logic              csr_we_o;
    logic [DATA_W-1:0] csr_wdata_o;
    logic [DATA_W-1:0] csr_rdata_i;
    logic              hold_flag_o;
    logic              rd_we_o;
    logic [4:0]        rd_idx_o;
    logic [DATA_W-1:0] rd_wdata_o;
    logic              done_o;
    logic              illegal_o;

    modport slave (
        input  req_valid_i, funct3_i, csr_addr_i, rs1_idx_i, rs1_data_i,
               rd_idx_i, csr_rdata_i,
        output req_ready_o, csr_addr_o, csr_we_o, csr_wdata_o, hold_flag_o,
               rd_we_o, rd_idx_o, rd_wdata_o, done_o, illegal_o
    );

    modport master (
        output req_valid_i, funct3_i, csr_addr_i, rs1_idx_i, rs1_data_i,
               rd_idx_i, csr_rdata_i,
        input  req_ready_o, csr_addr_o, csr_we_o, csr_wdata_o, hold_flag_o,
               rd_we_o, rd_idx_o, rd_wdata_o, done_o, illegal_o
    );
endinterface

// File: rtl/mxrv_csr_ctrl_alu.sv
// Combinational Zicsr datapath: operand select, new CSR value, and
// write-enable / illegal decode (ro_space marks a write-protected target).
module mxrv_csr_alu
    import mxrv_csr_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [2:0]        funct3,
    input  logic [4:0]        rs1_idx,
    input  logic [DATA_W-1:0] rs1_data,
    input  logic [DATA_W-1:0] old_val,
    input  logic              ro_space,
    output logic [DATA_W-1:0] new_val,
    output logic              wr_en,
    output logic              illegal
);
    logic [DATA_W-1:0] operand;
    logic              we_raw;
    logic              bad_f3;

    always_comb begin
        operand = funct3[2] ? {{(DATA_W-5){1'b0}}, rs1_idx} : rs1_data;
        new_val = operand;
        we_raw  = CSR_READ;
        bad_f3  = 1'b0;
        case (funct3)
            F3_CSRRW, F3_CSRRWI: begin
                new_val = operand;
                we_raw  = CSR_WRITE;
            end
            F3_CSRRS, F3_CSRRSI: begin
                new_val = old_val | operand;
                we_raw  = (rs1_idx != 5'd0);
            end
            F3_CSRRC, F3_CSRRCI: begin
                new_val = old_val & ~operand;
                we_raw  = (rs1_idx != 5'd0);
            end
            default: bad_f3 = 1'b1;
        endcase
        // A set/clear with rs1 = x0 never writes, so it stays legal on read-only CSRs.
        illegal = bad_f3 | (we_raw & ro_space);
        wr_en   = we_raw & ~ro_space;
    end
endmodule

// File: rtl/mxrv_csr_ctrl.sv
// Sequenced read-modify-write controller for Zicsr instructions; stalls the PC
// while busy. Define MXRV_CSR_RO_CHECK_EN to reject writes to 0xC00-0xFFF.
module mxrv_csr_ctrl
    import mxrv_csr_pkg::*;
#(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    mxrv_csr_ctrl_if.slave      bus,
    output csr_state_e          dbg_state
);
    csr_state_e        state, state_nxt;
    logic [2:0]        f3_q;
    logic [ADDR_W-1:0] addr_q;
    logic [4:0]        rs1_idx_q;
    logic [DATA_W-1:0] rs1_data_q;
    logic [4:0]        rd_idx_q;
    logic [DATA_W-1:0] old_q;
    logic [DATA_W-1:0] new_val;
    logic              wr_en;
    logic              illegal;
    logic              ro_space;
    logic              accept;

`ifdef MXRV_CSR_RO_CHECK_EN
    assign ro_space = (addr_q[ADDR_W-1 -: 2] == 2'b11);
`else
    assign ro_space = 1'b0;
`endif

    mxrv_csr_alu #(.DATA_W(DATA_W)) u_alu (
        .funct3   (f3_q),
        .rs1_idx  (rs1_idx_q),
        .rs1_data (rs1_data_q),
        .old_val  (old_q),
        .ro_space (ro_space),
        .new_val  (new_val),
        .wr_en    (wr_en),
        .illegal  (illegal)
    );

    assign accept    = (state == ST_IDLE) && bus.req_valid_i;
    assign dbg_state = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            f3_q       <= '0;
            addr_q     <= '0;
            rs1_idx_q  <= '0;
            rs1_data_q <= '0;
            rd_idx_q   <= '0;
            old_q      <= '0;
        end else begin
            if (accept) begin
                f3_q       <= bus.funct3_i;
                addr_q     <= bus.csr_addr_i;
                rs1_idx_q  <= bus.rs1_idx_i;
                rs1_data_q <= bus.rs1_data_i;
                rd_idx_q   <= bus.rd_idx_i;
            end
            // Register-file read data arrives one cycle after the address.
            if (state == ST_CAPTURE) begin
                old_q <= bus.csr_rdata_i;
            end
        end
    end

    always_comb begin
        state_nxt       = state;
        bus.req_ready_o = 1'b0;
        bus.hold_flag_o = 1'b1;
        bus.csr_addr_o  = '0;
        bus.csr_we_o    = CSR_READ;
        bus.csr_wdata_o = '0;
        bus.rd_we_o     = 1'b0;
        bus.rd_idx_o    = '0;
        bus.rd_wdata_o  = '0;
        bus.done_o      = 1'b0;
        bus.illegal_o   = 1'b0;
        case (state)
            ST_IDLE: begin
                bus.req_ready_o = 1'b1;
                bus.hold_flag_o = bus.req_valid_i;
                if (bus.req_valid_i) state_nxt = ST_READ;
            end
            ST_READ: begin
                bus.csr_addr_o = addr_q;
                state_nxt      = ST_CAPTURE;
            end
            ST_CAPTURE: begin
                bus.csr_addr_o = addr_q;
                state_nxt      = ST_WRITE;
            end
            ST_WRITE: begin
                bus.csr_addr_o  = addr_q;
                bus.csr_we_o    = wr_en ? CSR_WRITE : CSR_READ;
                bus.csr_wdata_o = new_val;
                state_nxt       = ST_DONE;
            end
            ST_DONE: begin
                bus.done_o     = 1'b1;
                bus.illegal_o  = illegal;
                bus.rd_we_o    = !illegal && (rd_idx_q != 5'd0);
                bus.rd_idx_o   = rd_idx_q;
                bus.rd_wdata_o = old_q;
                state_nxt      = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end
endmodule

// File: doc/mxrv_csr_ctrl.md
Name: mxrv_csr_ctrl

Overview:
- Initiator side of the CSR register-file port. It executes Zicsr instructions (CSRRW/CSRRS/CSRRC and the immediate forms) as a sequenced read-modify-write on mxrv_csr_reg.
- It returns the old CSR value for rd writeback.
- It raises hold_flag toward mxrv_pc_reg so the PC stalls while an access is in flight.
- Sits between decode/execute and mxrv_csr_reg.

Parameters:
- ADDR_W, 12, CSR address width.
- DATA_W, 32, CSR and GPR data width.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid_i  in  1  CSR instruction request.
- req_ready_o  out  1  controller idle and able to accept.
- funct3_i  in  3  Zicsr funct3 field.
- csr_addr_i  in  ADDR_W  target CSR.
- rs1_idx_i  in  5  rs1 index; doubles as zimm for immediate forms.
- rs1_data_i  in  DATA_W  rs1 register value.
- rd_idx_i  in  5  destination register index.
- csr_addr_o  out  ADDR_W  address to mxrv_csr_reg.
- csr_we_o  out  1  write enable to mxrv_csr_reg (`Write=1, `Read=0).
- csr_wdata_o  out  DATA_W  write data to mxrv_csr_reg.
- csr_rdata_i  in  DATA_W  read data from mxrv_csr_reg, valid the cycle after the address is presented.
- hold_flag_o  out  1  PC hold request.
- rd_we_o  out  1  GPR writeback strobe.
- rd_idx_o  out  5  writeback index.
- rd_wdata_o  out  DATA_W  old CSR value.
- done_o  out  1  one-cycle completion pulse.
- illegal_o  out  1  one-cycle illegal-instruction pulse, coincident with done_o.

Behaviour:
- Clock and reset: one clock (clk). Reset rst_n is asynchronous and active-low.
- Reset values: state IDLE; req_ready_o=1; all other outputs 0; captured registers 0.
- FSM states and transitions:
  - IDLE → READ when req_valid_i && req_ready_o. On this edge, latch funct3, addr, rs1 index/data and rd index.
  - READ (1 cycle): csr_addr_o=latched addr; csr_we_o=0.
  - CAPTURE (1 cycle): old_q <= csr_rdata_i; compute new value.
  - WRITE (1 cycle): csr_we_o=1 only if the write is enabled; csr_wdata_o=new value; csr_addr_o held.
  - DONE (1 cycle): done_o=1; rd_we_o=1 unless rd_idx==0 or illegal; rd_wdata_o=old_q; then → IDLE.
- Timing:
  - Fixed 4-cycle latency from accept to done_o.
  - req_ready_o=1 only in IDLE, so back-to-back requests accept on the cycle after DONE.
  - hold_flag_o=1 from the accept edge through DONE inclusive; combinationally high in IDLE while req_valid_i is high.
- Operand: operand = rs1_data for funct3[2]=0; operand = zero-extended rs1_idx (zimm) for funct3[2]=1.
- New value:
  - RW: new = operand.
  - RS: new = old | operand.
  - RC: new = old & ~operand.
- Write-enable rule:
  - RW/RWI always write.
  - RS/RC/RSI/RCI write only when rs1_idx!=0.
- Illegal: funct3 ∈ {000, 100}. Result is no CSR write, rd_we_o=0, illegal_o=1 in DONE.
- csr_addr_o/csr_wdata_o return to 0 in IDLE; csr_we_o is never high outside WRITE.
- Reset mid-operation:
  - Immediate abort to IDLE.
  - A write is committed only if the clock edge at the end of WRITE has occurred.
  - No done_o or rd_we_o is emitted.
- req_valid_i while busy is ignored; the requester must hold it until accepted.

Optional Feature:
- MXRV_CSR_RO_CHECK_EN.
- Defined: any enabled write to a CSR with addr[11:10]==2'b11 (read-only space) is flagged illegal. csr_we_o stays 0, rd_we_o=0, illegal_o=1.
- A read-only CSR accessed by RS/RC with rs1_idx==0 remains legal.
- Undefined: no address check; writes to 0xC00–0xFFF are passed to mxrv_csr_reg unchanged.

Decomposition:
- Package mxrv_csr_pkg holds:
  - funct3 encodings (CSRRW=001, CSRRS=010, CSRRC=011, CSRRWI=101, CSRRSI=110, CSRRCI=111);
  - FSM state enum;
  - CSR address constants (CSR_MSTATUS=0x300, CSR_MISA=0x301);
  - Read/Write enable constants.
- Sub-module mxrv_csr_alu: combinational operand select, new-value computation and write-enable/illegal decode.

Test Plan:
- CSRRW, addr 0x300, rs1=5, rs1_data=0xDEADBEEF, rd=3 → csr_we_o=1 with wdata 0xDEADBEEF in cycle 3; done_o in cycle 4; rd_wdata_o = prior mstatus; rd_we_o=1; hold_flag_o high cycles 0–4.
- mstatus=0x0000_00F0: CSRRS with rs1_data=0x0F, then CSRRC with rs1_data=0x30 → writes 0xFF, then 0xCF; rd returns 0xF0, then 0xFF.
- CSRRSI, addr 0x301, zimm=0, rd=7 → csr_we_o never asserted; rd_wdata_o = MISA value; rd_we_o=1.
- funct3=100 → illegal_o=1 and done_o=1 in cycle 4; no csr_we_o; rd_we_o=0. Then CSRRWI, zimm=0x1F, rd=0 → write 0x1F; rd_we_o=0.
- Assert rst_n=0 during CAPTURE of a CSRRW → outputs 0 immediately; target CSR unchanged; no done_o. The next request completes normally.
- MXRV_CSR_RO_CHECK_EN defined: CSRRW to 0xC00 → illegal_o=1, no write. Same stimulus with the macro undefined → csr_we_o=1 to 0xC00.
